// File: rtl/spi_rx_defs.sv
// Shared definitions for the SPI word receiver: FSM encodings and default sizing.
package spi_rx_defs;

   localparam logic StIdle  = 1'b0;
   localparam logic StShift = 1'b1;

   localparam int unsigned DefaultWordLength   = 32;
   localparam int unsigned DefaultStrobeCycles = 4;

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for one asynchronous input with a selectable reset value.
module bit_synchronizer #(
   parameter int unsigned STAGES      = 2,
   parameter logic        RESET_VALUE = 1'b0
) (
   input  logic clock,
   input  logic reset_n,
   input  logic async_in,
   output logic sync_out
);

   logic [STAGES-1:0] chain_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         chain_q <= {STAGES{RESET_VALUE}};
      end else begin
         chain_q <= {chain_q[STAGES-2:0], async_in};
      end
   end

   assign sync_out = chain_q[STAGES-1];

endmodule

// File: rtl/spi_word_receiver.sv
// Mode-0 SPI slave on the system clock: assembles MSB-first words, strobes each
// completed word to the controller and echoes the previous word on MISO.
module spi_word_receiver
   import spi_rx_defs::*;
#(
   parameter int unsigned WORD_LENGTH   = DefaultWordLength,
   parameter int unsigned STROBE_CYCLES = DefaultStrobeCycles,
   parameter int unsigned SYNC_STAGES   = 2
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   spi_sck,
   input  logic                   spi_cs_n,
   input  logic                   spi_mosi,
   output logic                   spi_miso,
   output logic [WORD_LENGTH-1:0] spi_data,
   output logic                   spi_data_clock,
   output logic                   frame_error,
   output logic [7:0]             word_count
);

   localparam int unsigned CntW    = $clog2(WORD_LENGTH);
   localparam int unsigned StrobeW = $clog2(STROBE_CYCLES + 1);

   logic sck_s, cs_n_s, mosi_s;
   logic sck_prev_q, cs_n_prev_q;
   logic sck_rise, sck_fall, cs_fall, cs_rise;

   logic                   state_q, state_d;
   logic [CntW-1:0]        bit_cnt_q, bit_cnt_d;
   logic [WORD_LENGTH-1:0] shift_q, shift_d;
   logic [WORD_LENGTH-1:0] data_q, data_d;
   logic [WORD_LENGTH-1:0] miso_q, miso_d;
   logic [7:0]             count_q, count_d;
   logic                   skip_fall_q, skip_fall_d;
   logic                   err_q, err_d;
   logic                   miso_out_q, miso_out_d;
   logic                   word_done, done_q;
   logic [StrobeW-1:0]     strobe_q, strobe_d;

   bit_synchronizer #(.STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_sync_sck (
      .clock    (clock),
      .reset_n  (reset_n),
      .async_in (spi_sck),
      .sync_out (sck_s)
   );

   bit_synchronizer #(.STAGES(SYNC_STAGES), .RESET_VALUE(1'b1)) u_sync_cs_n (
      .clock    (clock),
      .reset_n  (reset_n),
      .async_in (spi_cs_n),
      .sync_out (cs_n_s)
   );

   bit_synchronizer #(.STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_sync_mosi (
      .clock    (clock),
      .reset_n  (reset_n),
      .async_in (spi_mosi),
      .sync_out (mosi_s)
   );

   assign sck_rise = sck_s & ~sck_prev_q;
   assign sck_fall = ~sck_s & sck_prev_q;
   assign cs_fall  = ~cs_n_s & cs_n_prev_q;
   assign cs_rise  = cs_n_s & ~cs_n_prev_q;

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      data_d      = data_q;
      miso_d      = miso_q;
      count_d     = count_q;
      skip_fall_d = skip_fall_q;
      err_d       = 1'b0;
      word_done   = 1'b0;
      case (state_q)
         StIdle: begin
            if (cs_fall) begin
               state_d     = StShift;
               bit_cnt_d   = '0;
               miso_d      = data_q;
               skip_fall_d = 1'b0;
            end
         end
         StShift: begin
            if (sck_rise) begin
               shift_d = {shift_q[WORD_LENGTH-2:0], mosi_s};
               if (bit_cnt_q == CntW'(WORD_LENGTH - 1)) begin
                  word_done   = 1'b1;
                  data_d      = shift_d;
                  count_d     = count_q + 8'd1;
                  bit_cnt_d   = '0;
                  miso_d      = shift_d;
                  // The host has not sampled the reloaded MSB yet; keep it past this fall.
                  skip_fall_d = 1'b1;
               end else begin
                  bit_cnt_d = bit_cnt_q + CntW'(1);
               end
            end else if (sck_fall) begin
               if (skip_fall_q) begin
                  skip_fall_d = 1'b0;
               end else begin
                  miso_d = {miso_q[WORD_LENGTH-2:0], 1'b0};
               end
            end
            // A word completing in the same cycle leaves bit_cnt_d at zero: clean exit.
            if (cs_rise) begin
               state_d = StIdle;
               err_d   = (bit_cnt_d != '0);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign miso_out_d = (state_d == StShift) ? miso_d[WORD_LENGTH-1] : 1'b0;

   always_comb begin
      strobe_d = strobe_q;
      if (done_q) begin
         strobe_d = StrobeW'(STROBE_CYCLES);
      end else if (strobe_q != '0) begin
         strobe_d = strobe_q - StrobeW'(1);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sck_prev_q  <= 1'b0;
         cs_n_prev_q <= 1'b1;
         state_q     <= StIdle;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         data_q      <= '0;
         miso_q      <= '0;
         count_q     <= '0;
         skip_fall_q <= 1'b0;
         err_q       <= 1'b0;
         miso_out_q  <= 1'b0;
         done_q      <= 1'b0;
         strobe_q    <= '0;
      end else begin
         sck_prev_q  <= sck_s;
         cs_n_prev_q <= cs_n_s;
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         data_q      <= data_d;
         miso_q      <= miso_d;
         count_q     <= count_d;
         skip_fall_q <= skip_fall_d;
         err_q       <= err_d;
         miso_out_q  <= miso_out_d;
         done_q      <= word_done;
         strobe_q    <= strobe_d;
      end
   end

   assign spi_miso       = miso_out_q;
   assign spi_data       = data_q;
   assign spi_data_clock = (strobe_q != '0);
   assign frame_error    = err_q;
   assign word_count     = count_q;

endmodule

// File: tb/tb_spi_word_receiver.sv
// Bench for spi_word_receiver: transaction-level model scheduled by pin activity,
// checked every cycle, plus literal expectations per scenario.
module tb_spi_word_receiver;

   localparam int WL     = 32;
   localparam int STROBE = 4;
   localparam int SYNC   = 2;
   localparam int LAT    = SYNC + 1;

   logic        clock    = 1'b0;
   logic        reset_n  = 1'b0;
   logic        spi_sck  = 1'b0;
   logic        spi_cs_n = 1'b1;
   logic        spi_mosi = 1'b0;
   logic        spi_miso;
   logic [31:0] spi_data;
   logic        spi_data_clock;
   logic        frame_error;
   logic [7:0]  word_count;

   spi_word_receiver #(
      .WORD_LENGTH   (WL),
      .STROBE_CYCLES (STROBE),
      .SYNC_STAGES   (SYNC)
   ) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .spi_sck        (spi_sck),
      .spi_cs_n       (spi_cs_n),
      .spi_mosi       (spi_mosi),
      .spi_miso       (spi_miso),
      .spi_data       (spi_data),
      .spi_data_clock (spi_data_clock),
      .frame_error    (frame_error),
      .word_count     (word_count)
   );

   always #5 clock = ~clock;

   typedef struct {
      int          eff;
      bit          is_err;
      logic [31:0] word;
   } event_t;

   event_t evq[$];
   int checks = 0;
   int passes = 0;
   int fails  = 0;
   int cyc    = 0;

   // Expected output state, advanced when scheduled events mature
   logic [31:0] exp_data  = '0;
   int          exp_count = 0;
   int          last_upd  = -100;
   int          last_err  = -100;

   // Observed strobe / error shape
   int          strobe_rises = 0;
   int          strobe_len   = 0;
   int          strobe_gap   = 0;
   int          run_len      = 0;
   int          data_chg_cyc = 0;
   int          err_cycles   = 0;
   logic        prev_strobe  = 1'b0;
   logic [31:0] prev_data    = '0;

   // Host-side frame bookkeeping
   logic [31:0] last_word  = '0;
   logic [31:0] rx_word    = '0;
   logic [31:0] miso_exp   = '0;
   logic [31:0] miso_got   = '0;
   int          frame_bits = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got === want) begin
         passes++;
      end else begin
         fails++;
         if (fails <= 30) $display("FAIL %s: got %h expected %h at cycle %0d", name, got, want, cyc);
      end
   endtask

   initial begin : compare
      event_t e;
      forever begin
         @(posedge clock);
         cyc++;
         #1;
         while (evq.size() > 0 && evq[0].eff <= cyc) begin
            e = evq.pop_front();
            if (e.is_err) begin
               last_err = e.eff;
            end else begin
               exp_data  = e.word;
               exp_count = (exp_count + 1) % 256;
               last_upd  = e.eff;
            end
         end
         check("spi_data", spi_data, exp_data);
         check("word_count", 32'(word_count), 32'(exp_count));
         check("spi_data_clock", 32'(spi_data_clock),
               32'((cyc > last_upd && cyc <= last_upd + STROBE) ? 1 : 0));
         check("frame_error", 32'(frame_error), 32'((cyc == last_err) ? 1 : 0));
         if (spi_data !== prev_data) data_chg_cyc = cyc;
         if (spi_data_clock && !prev_strobe) begin
            strobe_rises++;
            strobe_gap = cyc - data_chg_cyc;
            run_len    = 0;
         end
         if (spi_data_clock) run_len++;
         if (!spi_data_clock && prev_strobe) strobe_len = run_len;
         if (frame_error) err_cycles++;
         prev_strobe = spi_data_clock;
         prev_data   = spi_data;
      end
   end

   initial begin : watchdog
      #1_500_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1, "watchdog expired");
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset_n  = 1'b0;
      spi_sck  = 1'b0;
      spi_cs_n = 1'b1;
      spi_mosi = 1'b0;
      evq.delete();
      exp_data   = '0;
      exp_count  = 0;
      last_upd   = -100;
      last_err   = -100;
      last_word  = '0;
      frame_bits = 0;
      #1;
      check("reset spi_data", spi_data, 32'h0);
      check("reset word_count", 32'(word_count), 32'h0);
      check("reset spi_data_clock", 32'(spi_data_clock), 32'h0);
      check("reset frame_error", 32'(frame_error), 32'h0);
      check("reset spi_miso", 32'(spi_miso), 32'h0);
      wait_cycles(3);
      reset_n = 1'b1;
      wait_cycles(4);
   endtask

   task automatic start_frame();
      spi_cs_n   = 1'b0;
      frame_bits = 0;
      rx_word    = '0;
      miso_got   = '0;
      miso_exp   = last_word;
      wait_cycles(4);
   endtask

   task automatic rise(input logic b, input int lo, input bit cs_too);
      spi_mosi = b;
      wait_cycles(lo);
      miso_got = {miso_got[30:0], spi_miso};
      spi_sck  = 1'b1;
      if (cs_too) spi_cs_n = 1'b1;
      rx_word = {rx_word[30:0], b};
      frame_bits++;
      if (frame_bits == WL) begin
         evq.push_back('{eff: cyc + LAT, is_err: 1'b0, word: rx_word});
         check("miso stream", miso_got, miso_exp);
         miso_exp   = rx_word;
         last_word  = rx_word;
         frame_bits = 0;
      end
   endtask

   task automatic fall(input int hi);
      wait_cycles(hi);
      spi_sck = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input int lo, input int hi);
      for (int i = 31; i >= 0; i--) begin
         rise(w[i], lo, 1'b0);
         fall(hi);
      end
   endtask

   task automatic end_frame();
      wait_cycles(4);
      spi_cs_n = 1'b1;
      if (frame_bits != 0) evq.push_back('{eff: cyc + LAT, is_err: 1'b1, word: 32'h0});
      frame_bits = 0;
      wait_cycles(8);
      check("miso idle", 32'(spi_miso), 32'h0);
   endtask

   initial begin : stimulus
      int          r0;
      int          e0;
      logic [31:0] w;
      do_reset();

      // Single word at clock/8
      start_frame();
      send_word(32'hA5A5_1234, 4, 4);
      end_frame();
      check("t1 data", spi_data, 32'hA5A5_1234);
      check("t1 count", 32'(word_count), 32'd1);
      check("t1 strobe length", 32'(strobe_len), 32'd4);
      check("t1 strobe gap", 32'(strobe_gap), 32'd1);

      // Back-to-back words without CS toggle
      do_reset();
      r0 = strobe_rises;
      start_frame();
      send_word(32'h0000_0001, 4, 4);
      send_word(32'hFFFF_FFFE, 4, 4);
      end_frame();
      check("t2 data", spi_data, 32'hFFFF_FFFE);
      check("t2 count", 32'(word_count), 32'd2);
      check("t2 strobes", 32'(strobe_rises - r0), 32'd2);

      // Aborted frame after 13 bits, then a good word
      r0 = strobe_rises;
      e0 = err_cycles;
      w  = 32'h55AA_55AA;
      start_frame();
      for (int i = 31; i >= 19; i--) begin
         rise(w[i], 4, 1'b0);
         fall(4);
      end
      end_frame();
      check("t3 error cycles", 32'(err_cycles - e0), 32'd1);
      check("t3 data kept", spi_data, 32'hFFFF_FFFE);
      check("t3 no strobe", 32'(strobe_rises - r0), 32'd0);
      start_frame();
      send_word(32'hDEAD_BEEF, 4, 4);
      end_frame();
      check("t3 data", spi_data, 32'hDEAD_BEEF);
      check("t3 count", 32'(word_count), 32'd3);

      // Reset during bit 20, then during the strobe
      w = 32'h1357_2468;
      start_frame();
      for (int i = 31; i >= 13; i--) begin
         rise(w[i], 4, 1'b0);
         fall(4);
      end
      rise(w[12], 4, 1'b0);
      wait_cycles(1);
      do_reset();
      w = 32'hCAFE_F00D;
      start_frame();
      for (int i = 31; i >= 1; i--) begin
         rise(w[i], 4, 1'b0);
         fall(4);
      end
      rise(w[0], 4, 1'b0);
      wait_cycles(5);
      check("t4 strobe before reset", 32'(spi_data_clock), 32'd1);
      do_reset();
      start_frame();
      send_word(32'h0BAD_F00D, 4, 4);
      end_frame();
      check("t4 data", spi_data, 32'h0BAD_F00D);
      check("t4 count", 32'(word_count), 32'd1);

      // CS rises together with the final SCK rise
      e0 = err_cycles;
      w  = 32'h1357_9BDF;
      start_frame();
      for (int i = 31; i >= 1; i--) begin
         rise(w[i], 4, 1'b0);
         fall(4);
      end
      rise(w[0], 4, 1'b1);
      fall(4);
      wait_cycles(8);
      check("t5 data", spi_data, 32'h1357_9BDF);
      check("t5 count", 32'(word_count), 32'd2);
      check("t5 no error", 32'(err_cycles - e0), 32'd0);

      // Minimum legal SCK phases, random data
      e0 = err_cycles;
      start_frame();
      for (int k = 0; k < 6; k++) send_word($urandom, LAT, LAT);
      end_frame();
      check("t6 data", spi_data, last_word);
      check("t6 count", 32'(word_count), 32'd8);
      check("t6 no error", 32'(err_cycles - e0), 32'd0);

      // 256 words wrap the counter
      do_reset();
      start_frame();
      for (int k = 0; k < 256; k++) begin
         w = {24'hC0FFEE, 8'(k)};
         send_word(w, LAT, LAT);
      end
      end_frame();
      check("t7 count wrap", 32'(word_count), 32'd0);
      check("t7 last data", spi_data, 32'hC0FF_EEFF);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
